rx_controller: RTL and testbench
================================

# rx_controller

Receive-path controller of the UART peripheral. It owns the `rx_frontend` instance's configuration and reset sequencing and buffers decoded frames in a small FIFO. It exposes data, per-frame error flags and sticky status to the Wishbone register bank. It sits between the register bank (CR writes, RX data reads) and `rx_frontend` (frame decode).

## Interface
Parameters:
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cr_clk_div_i`  in  16  requested baud divider from CR.
- `cr_ds_i`  in  1  requested data size; 1 = 8 bits, 0 = 7 bits.
- `cr_p_i`  in  2  requested parity mode.
- `cr_s_i`  in  1  requested stop-bit count.
- `cr_wr_i`  in  1  one-cycle strobe: CR was written.
- `fe_rst_o`  out  1  reset to `rx_frontend`, ORed with `rst_i` at the instance.
- `fe_clk_div_o`  out  16  shadow divider to frontend.
- `fe_ds_o`  out  1  shadow data size to frontend.
- `fe_p_o`  out  2  shadow parity mode to frontend.
- `fe_s_o`  out  1  shadow stop-bit count to frontend.
- `fe_frame_i`  in  11  decoded frame; data is right-aligned in `[7:0]`, and bit 7 is ignored when `fe_ds_o`=0.
- `fe_parity_err_i`  in  1  parity error for the current frame.
- `fe_frame_err_i`  in  1  stop-bit error for the current frame.
- `fe_valid_i`  in  1  one-cycle pulse: the frame and error fields are valid.
- `rx_data_o`  out  8  head entry data; 0 when empty.
- `rx_pe_o`  out  1  head entry parity error.
- `rx_fe_o`  out  1  head entry frame error.
- `rxne_o`  out  1  FIFO not empty.
- `rx_full_o`  out  1  FIFO full.
- `rd_i`  in  1  one-cycle pop strobe (RX data register read).
- `ovr_o`  out  1  sticky overrun flag.
- `clr_ovr_i`  in  1  clears `ovr_o`.

## Operation
- States: `CFG`, `FLUSH`, `RUN`.
  - `CFG`: load the shadow registers from the `cr_*` inputs and assert `fe_rst_o`.
  - `FLUSH`: hold `fe_rst_o`=1 for one more cycle.
  - `RUN`: `fe_rst_o`=0 and frames are accepted.
- Transitions:
  - reset → `CFG`.
  - `CFG` → `FLUSH` → `RUN`, unconditionally.
  - `cr_wr_i`=1 in any state → `CFG` next cycle. This restarts the sequence if it arrives mid-sequence.
- Shadow configuration changes only in `CFG`. The frontend never sees CR bits change while it is running.
- Push: when `fe_valid_i`=1 in `RUN`, write {data masked to 7 bits when `fe_ds_o`=0, `fe_parity_err_i`, `fe_frame_err_i`}.
  - `fe_valid_i` outside `RUN` is discarded and does not set `ovr`.
- Overrun: a push while full with no same-cycle pop drops the new frame and sets `ovr_o`.
- Full with same-cycle push and pop: both are performed, count is unchanged, and `ovr` is not set.
- Pop: `rd_i` when empty is ignored. Otherwise the head advances.
- Simultaneous `clr_ovr_i` and a new overrun: the set wins.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(FIFO_DEPTH)+1` bits.
- The FIFO is not flushed by a `cr_wr_i` reconfiguration. Only `rst_i` empties it.

## Timing
- Reset values:
  - state = `CFG`, `fe_rst_o`=1.
  - Shadow registers = 0.
  - `rx_data_o`=0, `rx_pe_o`=0, `rx_fe_o`=0.
  - `rxne_o`=0, `rx_full_o`=0, `ovr_o`=0.
- After `rst_i` deasserts at cycle N: `fe_rst_o`=1 in N and N+1, and =0 from N+2 (`RUN`).
- `cr_wr_i` at cycle N: the shadow updates at the N+1 edge, `fe_rst_o`=1 for cycles N+1 and N+2, and the block is in `RUN` at N+3.
- `fe_valid_i` at cycle N in `RUN`: `rxne_o`=1 and head data are visible at N+1.
- `rd_i` at cycle N: the next entry (or empty) is visible at N+1. `rxne_o` falls at N+1 when the last entry is popped.
- `ovr_o` rises the cycle after the dropping push. It clears the cycle after `clr_ovr_i`.
- All outputs are registered or driven directly from storage, with no combinational path from `rd_i` or `fe_valid_i`.

## Structure
- Package `rx_controller_pkg`:
  - `rx_ctrl_state_t` enum (`CFG`, `FLUSH`, `RUN`).
  - `rx_entry_t` packed struct {data[7:0], pe, fe}.
- Sub-module `rx_fifo`: a synchronous FIFO parameterised by depth and entry width. It has push/pop/full/empty and registered head-read output.
- `rx_controller` contains the FSM, shadow registers, masking and overrun logic.

## Test plan
- Reset release with `cr_clk_div_i`=16'd868, `cr_ds_i`=1 → `fe_rst_o` high 2 cycles, `fe_clk_div_o`=868 from the 1st post-reset cycle, `RUN` on the 3rd.
- Push 0xA5 with `fe_ds_o`=1, then 0xFF with `fe_ds_o`=0 → reads return 0xA5 then 0x7F, and `rxne_o` falls after the 2nd `rd_i`.
- Push a frame with `fe_parity_err_i`=1 and `fe_frame_err_i`=0 → `rx_pe_o`=1 and `rx_fe_o`=0 with that entry only; the next entry shows `rx_pe_o`=0.
- Fill 4 entries, then push a 5th alone → `rx_full_o`=1, `ovr_o`=1, and the 5th is lost. In the next test, push and pop in the same cycle while full → no `ovr`, and the order is preserved.
- `cr_wr_i` while in `FLUSH`, with `fe_valid_i` pulsed during `CFG` → sequence restarts, frame discarded, FIFO contents intact.
- `clr_ovr_i` coincident with a dropping push → `ovr_o` stays 1. `clr_ovr_i` alone → `ovr_o`=0 next cycle.

Source files
------------

// File: rtl/rx_controller_pkg.sv
// Shared types for the UART receive controller: FSM states, FIFO entry layout
// and the data-size masking helper.
package rx_controller_pkg;

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } rx_ctrl_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  // 7-bit frames leave bit 7 undefined on the frontend side, so force it low.
  function automatic logic [7:0] mask_data(input logic [7:0] d, input logic ds);
    return ds ? d : {1'b0, d[6:0]};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with a registered head output; the head register is
// precomputed from the next-state pointers so no output depends on push/pop.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]      count, count_n;
  logic [WIDTH-1:0] head_q, head_n;
  logic             push_eff, pop_eff;

  always_comb begin
    pop_eff  = pop && (count != '0);
    // A push into a full FIFO only lands when the same cycle frees a slot.
    push_eff = push && ((count != FULL_CNT) || pop_eff);
    rd_ptr_n = rd_ptr + AW'(pop_eff);
    count_n  = count;
    if (push_eff && !pop_eff)      count_n = count + 1'b1;
    else if (!push_eff && pop_eff) count_n = count - 1'b1;
    head_n = mem[rd_ptr_n];
    if (count_n == '0)                          head_n = '0;
    else if (push_eff && (wr_ptr == rd_ptr_n))  head_n = wdata;
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      head_q <= head_n;
    end
  end

  assign rdata = head_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/rx_controller.sv
// UART receive controller: sequences frontend config/reset, buffers decoded
// frames with their error flags and tracks a sticky overrun flag.
module rx_controller
  import rx_controller_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        cr_wr_i,
  output logic        fe_rst_o,
  output logic [15:0] fe_clk_div_o,
  output logic        fe_ds_o,
  output logic [1:0]  fe_p_o,
  output logic        fe_s_o,
  input  logic [10:0] fe_frame_i,
  input  logic        fe_parity_err_i,
  input  logic        fe_frame_err_i,
  input  logic        fe_valid_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_pe_o,
  output logic        rx_fe_o,
  output logic        rxne_o,
  output logic        rx_full_o,
  input  logic        rd_i,
  output logic        ovr_o,
  input  logic        clr_ovr_i
);

  rx_ctrl_state_t state, state_n;
  rx_entry_t      wentry, head;
  logic           push, overrun, full, empty, ovr_q;
  logic           unused_frame_hi;

  always_comb begin
    state_n = state;
    case (state)
      CFG:     state_n = FLUSH;
      FLUSH:   state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = CFG;
    endcase
    if (cr_wr_i) state_n = CFG;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= CFG;
    else       state <= state_n;
  end

  // Shadow loads land while the frontend is held in reset, never while running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fe_clk_div_o <= '0;
      fe_ds_o      <= 1'b0;
      fe_p_o       <= '0;
      fe_s_o       <= 1'b0;
    end else if (state == CFG || cr_wr_i) begin
      fe_clk_div_o <= cr_clk_div_i;
      fe_ds_o      <= cr_ds_i;
      fe_p_o       <= cr_p_i;
      fe_s_o       <= cr_s_i;
    end
  end

  assign fe_rst_o = (state != RUN);

  assign unused_frame_hi = ^fe_frame_i[10:8];

  always_comb begin
    wentry.data = mask_data(fe_frame_i[7:0], fe_ds_o);
    wentry.pe   = fe_parity_err_i;
    wentry.fe   = fe_frame_err_i;
  end

  assign push    = fe_valid_i && (state == RUN);
  // When full the FIFO is non-empty, so any rd_i is a real pop that frees a slot.
  assign overrun = push && full && !rd_i;

  rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wentry),
    .pop   (rd_i),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)          ovr_q <= 1'b0;
    else if (overrun)   ovr_q <= 1'b1;
    else if (clr_ovr_i) ovr_q <= 1'b0;
  end

  assign rx_data_o = head.data;
  assign rx_pe_o   = head.pe;
  assign rx_fe_o   = head.fe;
  assign rxne_o    = !empty;
  assign rx_full_o = full;
  assign ovr_o     = ovr_q;

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: reset/config sequencing, FIFO ordering,
// error flags, overrun and reconfiguration corner cases.
module tb_rx_controller;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] cr_clk_div_i;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic        cr_wr_i;
  logic        fe_rst_o;
  logic [15:0] fe_clk_div_o;
  logic        fe_ds_o;
  logic [1:0]  fe_p_o;
  logic        fe_s_o;
  logic [10:0] fe_frame_i;
  logic        fe_parity_err_i;
  logic        fe_frame_err_i;
  logic        fe_valid_i;
  logic [7:0]  rx_data_o;
  logic        rx_pe_o;
  logic        rx_fe_o;
  logic        rxne_o;
  logic        rx_full_o;
  logic        rd_i;
  logic        ovr_o;
  logic        clr_ovr_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_controller #(.FIFO_DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cr_clk_div_i    (cr_clk_div_i),
    .cr_ds_i         (cr_ds_i),
    .cr_p_i          (cr_p_i),
    .cr_s_i          (cr_s_i),
    .cr_wr_i         (cr_wr_i),
    .fe_rst_o        (fe_rst_o),
    .fe_clk_div_o    (fe_clk_div_o),
    .fe_ds_o         (fe_ds_o),
    .fe_p_o          (fe_p_o),
    .fe_s_o          (fe_s_o),
    .fe_frame_i      (fe_frame_i),
    .fe_parity_err_i (fe_parity_err_i),
    .fe_frame_err_i  (fe_frame_err_i),
    .fe_valid_i      (fe_valid_i),
    .rx_data_o       (rx_data_o),
    .rx_pe_o         (rx_pe_o),
    .rx_fe_o         (rx_fe_o),
    .rxne_o          (rxne_o),
    .rx_full_o       (rx_full_o),
    .rd_i            (rd_i),
    .ovr_o           (ovr_o),
    .clr_ovr_i       (clr_ovr_i)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [10:0] frame;
    logic        pe;
    logic        fe;
    logic        rd;
    logic        clr;
    logic        x_rxne;
    logic        x_full;
    logic [7:0]  x_data;
    logic        x_pe;
    logic        x_fe;
    logic        x_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cr_wr_i = 1'b0; fe_valid_i = 1'b0; fe_parity_err_i = 1'b0;
    fe_frame_err_i = 1'b0; rd_i = 1'b0; clr_ovr_i = 1'b0; fe_frame_i = '0;
  endtask

  task automatic add(input string n, input logic v, input logic [10:0] f, input logic pe,
                     input logic fe, input logic rd, input logic clr, input logic xr,
                     input logic xf, input logic [7:0] xd, input logic xpe,
                     input logic xfe, input logic xo);
    vec_t t;
    t.name = n; t.valid = v; t.frame = f; t.pe = pe; t.fe = fe; t.rd = rd; t.clr = clr;
    t.x_rxne = xr; t.x_full = xf; t.x_data = xd; t.x_pe = xpe; t.x_fe = xfe; t.x_ovr = xo;
    vecs.push_back(t);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    cr_clk_div_i = 16'd868; cr_ds_i = 1'b1; cr_p_i = 2'b01; cr_s_i = 1'b1;
    tick(); tick();
    chk("rst_fe_rst", fe_rst_o, 1);
    chk("rst_div", fe_clk_div_o, 0);
    chk("rst_data", {rx_data_o, rx_pe_o, rx_fe_o}, 0);
    chk("rst_flags", {rxne_o, rx_full_o, ovr_o}, 0);

    rst_i = 1'b0;                       // cycle N
    chk("rel_N_fe_rst", fe_rst_o, 1);
    tick();                             // N+1
    chk("rel_N1_fe_rst", fe_rst_o, 1);
    chk("rel_N1_div", fe_clk_div_o, 868);
    chk("rel_N1_cfg", {fe_ds_o, fe_p_o, fe_s_o}, 4'b1011);
    tick();                             // N+2
    chk("rel_N2_run", fe_rst_o, 0);

    // FIFO behaviour at 8-bit data size
    add("push_a5",    1, 11'h0A5, 0, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 0);
    add("push_3c_pe", 1, 11'h53C, 1, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 0);
    add("pop_to_3c",  0, 11'h000, 0, 0, 1, 0, 1, 0, 8'h3C, 1, 0, 0);
    add("pop_empty",  0, 11'h000, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add("rd_on_empty",0, 11'h000, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add("fill_01",    1, 11'h001, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0, 0);
    add("fill_02",    1, 11'h002, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0, 0);
    add("fill_03",    1, 11'h003, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0, 0);
    add("fill_04",    1, 11'h004, 0, 1, 0, 0, 1, 1, 8'h01, 0, 0, 0);
    add("drop_05",    1, 11'h005, 0, 0, 0, 0, 1, 1, 8'h01, 0, 0, 1);
    add("clr_ovr",    0, 11'h000, 0, 0, 0, 1, 1, 1, 8'h01, 0, 0, 0);
    add("full_pp_06", 1, 11'h006, 0, 0, 1, 0, 1, 1, 8'h02, 0, 0, 0);
    add("drop_clr_07",1, 11'h007, 0, 0, 0, 1, 1, 1, 8'h02, 0, 0, 1);
    add("pop_03",     0, 11'h000, 0, 0, 1, 0, 1, 0, 8'h03, 0, 0, 1);
    add("pop_04",     0, 11'h000, 0, 0, 1, 0, 1, 0, 8'h04, 0, 1, 1);
    add("pop_06",     0, 11'h000, 0, 0, 1, 0, 1, 0, 8'h06, 0, 0, 1);
    add("pop_last",   0, 11'h000, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    add("clr_alone",  0, 11'h000, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      fe_valid_i = vecs[i].valid; fe_frame_i = vecs[i].frame;
      fe_parity_err_i = vecs[i].pe; fe_frame_err_i = vecs[i].fe;
      rd_i = vecs[i].rd; clr_ovr_i = vecs[i].clr;
      tick();
      chk({vecs[i].name, "_rxne"}, rxne_o, vecs[i].x_rxne);
      chk({vecs[i].name, "_full"}, rx_full_o, vecs[i].x_full);
      chk({vecs[i].name, "_head"}, {rx_data_o, rx_pe_o, rx_fe_o},
          {vecs[i].x_data, vecs[i].x_pe, vecs[i].x_fe});
      chk({vecs[i].name, "_ovr"}, ovr_o, vecs[i].x_ovr);
      idle_inputs();
    end

    // Shadow must hold while running even if CR inputs move without a write
    cr_clk_div_i = 16'd1234;
    tick();
    chk("shadow_hold_run", fe_clk_div_o, 868);

    // Reconfigure to 7-bit with one entry buffered; restart mid-sequence
    fe_valid_i = 1'b1; fe_frame_i = 11'h0A5;
    tick();
    idle_inputs();
    chk("pre_cfg_head", {rxne_o, rx_data_o}, {1'b1, 8'hA5});
    cr_ds_i = 1'b0; cr_wr_i = 1'b1;     // cycle N
    tick();                             // N+1: CFG
    cr_wr_i = 1'b0;
    chk("wr_N1_fe_rst", fe_rst_o, 1);
    fe_valid_i = 1'b1; fe_frame_i = 11'h0FF;   // discarded in CFG
    tick();                             // N+2: FLUSH
    idle_inputs();
    chk("wr_N2_fe_rst", fe_rst_o, 1);
    chk("wr_N2_ds", fe_ds_o, 0);
    chk("wr_N2_div", fe_clk_div_o, 1234);
    chk("wr_N2_ovr", ovr_o, 0);
    cr_wr_i = 1'b1;                     // restart while in FLUSH
    tick();
    cr_wr_i = 1'b0;
    chk("restart_cfg", fe_rst_o, 1);
    tick();
    chk("restart_flush", fe_rst_o, 1);
    tick();
    chk("restart_run", fe_rst_o, 0);
    chk("fifo_intact", {rxne_o, rx_full_o, rx_data_o}, {1'b1, 1'b0, 8'hA5});

    fe_valid_i = 1'b1; fe_frame_i = 11'h0FF;
    tick();
    idle_inputs();
    chk("ds7_head_still_a5", rx_data_o, 8'hA5);
    rd_i = 1'b1;
    tick();
    chk("ds7_masked", {rxne_o, rx_data_o}, {1'b1, 8'h7F});
    tick();
    rd_i = 1'b0;
    chk("ds7_empty", {rxne_o, rx_data_o}, {1'b0, 8'h00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
